// File: rtl/seq_player.sv
// -----------------------------------------------------------------------------
// seq_player
//   Steps through a small register file of 4-bit digits and shows the digit at
//   the current index on an active-low seven-segment output. The index moves
//   either on a manual step request or automatically every PRESCALE cycles,
//   in the direction selected by dir, wrapping at both ends.
//
// Parameters
//   SEQ_LEN   number of sequence entries (2..16)
//   PRESCALE  clock cycles per auto-advance (1..65535)
//
// Configuration macro
//   SEQ_PLAYER_BLANK_EN  defined: digits 10..15 blank the display.
//                        undefined: digits 10..15 show A b C d E F.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset, wins over every other input
//   dir       1 = forward (index+1), 0 = backward (index-1)
//   mode      0 = manual step, 1 = auto-advance
//   step      manual advance request (ignored in auto mode)
//   hold      freezes index and prescaler
//   wr_en     entry write strobe
//   wr_addr   entry to write; addresses >= SEQ_LEN are ignored
//   wr_digit  value to write
//   hex       active-low segments {g,f,e,d,c,b,a} of entry[idx]
//   idx       current index
//   wrap      one-cycle pulse following an advance that wrapped
// -----------------------------------------------------------------------------
module seq_player #(
   parameter int SEQ_LEN  = 5,
   parameter int PRESCALE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dir,
   input  logic       mode,
   input  logic       step,
   input  logic       hold,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] wr_digit,
   output logic [6:0] hex,
   output logic [3:0] idx,
   output logic       wrap
);

   localparam logic [3:0]  LAST_IDX = 4'(SEQ_LEN - 1);
   localparam logic [4:0]  LEN      = 5'(SEQ_LEN);
   localparam logic [15:0] PS_TOP   = 16'(PRESCALE - 1);

   logic [3:0]  entry [SEQ_LEN];
   logic [15:0] pres;
   logic        advance;
   logic        at_end;
   logic [3:0]  cur_digit;

   // Power-up contents of the sequence; entries past the first five are zero.
   function automatic logic [3:0] default_digit(input int i);
      case (i)
         0:       return 4'd6;
         1:       return 4'd0;
         2:       return 4'd4;
         3:       return 4'd8;
         4:       return 4'd3;
         default: return 4'd0;
      endcase
   endfunction

   // In auto mode the step input is deliberately ignored.
   assign advance = !hold && (mode ? (pres == PS_TOP) : step);

   // The index sits on the boundary it would leave in the current direction.
   assign at_end = dir ? (idx == LAST_IDX) : (idx == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         idx  <= 4'd0;
         pres <= 16'd0;
         wrap <= 1'b0;
         // NOTE: the entry file is a handful of flops with defined power-up
         // digits, so it is reset like any other state rather than left as RAM.
         for (int i = 0; i < SEQ_LEN; i++) begin
            entry[i] <= default_digit(i);
         end
      end else begin
         // NOTE: all state here uses non-blocking assignments so that the
         // write, prescaler and index updates all see pre-edge values.
         if (wr_en && ({1'b0, wr_addr} < LEN)) begin
            entry[wr_addr] <= wr_digit;
         end

         if (!mode) begin
            pres <= 16'd0;
         end else if (hold) begin
            pres <= pres;
         end else if (advance) begin
            pres <= 16'd0;
         end else begin
            pres <= pres + 16'd1;
         end

         if (advance) begin
            if (at_end) begin
               idx <= dir ? 4'd0 : LAST_IDX;
            end else begin
               idx <= dir ? idx + 4'd1 : idx - 4'd1;
            end
         end

         wrap <= advance && at_end;
      end
   end

   assign cur_digit = entry[idx];

   always_comb begin
      // NOTE: hex gets a value before the case so no path can infer a latch.
      hex = 7'b1111111;
      case (cur_digit)
         4'd0:  hex = 7'b1000000;
         4'd1:  hex = 7'b1111001;
         4'd2:  hex = 7'b0100100;
         4'd3:  hex = 7'b0110000;
         4'd4:  hex = 7'b0011001;
         4'd5:  hex = 7'b0010010;
         4'd6:  hex = 7'b0000010;
         4'd7:  hex = 7'b1111000;
         4'd8:  hex = 7'b0000000;
         4'd9:  hex = 7'b0010000;
`ifdef SEQ_PLAYER_BLANK_EN
         default: hex = 7'b1111111;
`else
         4'd10: hex = 7'b0001000;
         4'd11: hex = 7'b0000011;
         4'd12: hex = 7'b1000110;
         4'd13: hex = 7'b0100001;
         4'd14: hex = 7'b0000110;
         4'd15: hex = 7'b0001110;
         default: hex = 7'b1111111;
`endif
      endcase
   end

endmodule

// File: tb/tb_seq_player.sv
// -----------------------------------------------------------------------------
// tb_seq_player
//   Directed bench for seq_player. A table of single-cycle vectors covers
//   reset state, manual stepping in both directions, writes (in and out of
//   range, coincident with an advance, during reset) and the start of auto
//   mode. Hand-written sequences then cover hold, mid-run direction change,
//   prescaler clearing in manual mode, reset mid-count and a 16-entry
//   forward auto run.
// -----------------------------------------------------------------------------
module tb_seq_player;

   logic       clk = 1'b0;
   logic       reset, dir, mode, step, hold, wr_en;
   logic [3:0] wr_addr, wr_digit;
   logic [6:0] hex;
   logic [3:0] idx;
   logic       wrap;

   logic       r16, s16, dir16, mode16, hold16, we16;
   logic [3:0] wa16, wd16;
   logic [6:0] hex16;
   logic [3:0] idx16;
   logic       wrap16;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_player #(.SEQ_LEN(5), .PRESCALE(4)) dut (
      .clk(clk), .reset(reset), .dir(dir), .mode(mode), .step(step),
      .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_digit(wr_digit),
      .hex(hex), .idx(idx), .wrap(wrap)
   );

   seq_player #(.SEQ_LEN(16), .PRESCALE(2)) dut16 (
      .clk(clk), .reset(r16), .dir(dir16), .mode(mode16), .step(s16),
      .hold(hold16), .wr_en(we16), .wr_addr(wa16), .wr_digit(wd16),
      .hex(hex16), .idx(idx16), .wrap(wrap16)
   );

   typedef struct {
      logic       rst, md, dr, st, hl, we;
      logic [3:0] addr, dig;
      logic [3:0] e_idx, e_dig;
      logic       e_wrap;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mk(input logic rst, md, dr, st, hl, we,
                               input logic [3:0] addr, dig,
                               input logic [3:0] e_idx, e_dig,
                               input logic e_wrap);
      vec_t v;
      v.rst = rst; v.md = md; v.dr = dr; v.st = st; v.hl = hl; v.we = we;
      v.addr = addr; v.dig = dig;
      v.e_idx = e_idx; v.e_dig = e_dig; v.e_wrap = e_wrap;
      return v;
   endfunction

   // Reference segment table, active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
`ifdef SEQ_PLAYER_BLANK_EN
         default: return 7'b1111111;
`else
         4'd10: return 7'b0001000;
         4'd11: return 7'b0000011;
         4'd12: return 7'b1000110;
         4'd13: return 7'b0100001;
         4'd14: return 7'b0000110;
         default: return 7'b0001110;
`endif
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Advance one clock and compare the main DUT's outputs 1 ns after the edge.
   task automatic cyc(input string name, input logic [3:0] e_idx,
                      input logic [3:0] e_dig, input logic e_wrap);
      @(posedge clk);
      #1;
      check({name, " idx"},  {4'd0, idx},  {4'd0, e_idx});
      check({name, " hex"},  {1'b0, hex},  {1'b0, seg(e_dig)});
      check({name, " wrap"}, {7'd0, wrap}, {7'd0, e_wrap});
   endtask

   initial begin
      //             rst md dr st hl we addr   dig     idx    dig    wrap
      tbl[0]  = mk(1, 0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd6,  0); // reset state
      tbl[1]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd1, 4'd0,  0);
      tbl[2]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd2, 4'd4,  0);
      tbl[3]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd3, 4'd8,  0);
      tbl[4]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd4, 4'd3,  0);
      tbl[5]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd6,  1); // forward wrap
      tbl[6]  = mk(0, 0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd6,  0); // wrap drops
      tbl[7]  = mk(0, 0, 1, 1, 1, 0, 4'd0, 4'd0,  4'd0, 4'd6,  0); // hold blocks step
      tbl[8]  = mk(1, 0, 0, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd6,  0);
      tbl[9]  = mk(0, 0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd4, 4'd3,  1); // backward wrap
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 4'd0, 4'd0,  4'd4, 4'd3,  0);
      tbl[11] = mk(0, 0, 0, 0, 0, 1, 4'd7, 4'd9,  4'd4, 4'd3,  0); // out of range
      tbl[12] = mk(0, 0, 0, 0, 0, 1, 4'd2, 4'd12, 4'd4, 4'd3,  0);
      tbl[13] = mk(0, 0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd3, 4'd8,  0);
      tbl[14] = mk(0, 0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd2, 4'd12, 0); // C or blank
      tbl[15] = mk(0, 0, 0, 0, 0, 1, 4'd2, 4'd5,  4'd2, 4'd5,  0); // write at idx
      tbl[16] = mk(0, 0, 0, 1, 0, 1, 4'd2, 4'd9,  4'd1, 4'd0,  0); // write + advance
      tbl[17] = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd2, 4'd9,  0); // write landed
      tbl[18] = mk(1, 0, 1, 0, 0, 1, 4'd2, 4'd1,  4'd0, 4'd6,  0); // reset beats write
      tbl[19] = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd1, 4'd0,  0);
      tbl[20] = mk(0, 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'd2, 4'd4,  0); // default restored
      tbl[21] = mk(0, 1, 1, 1, 0, 0, 4'd0, 4'd0,  4'd2, 4'd4,  0); // auto, step ignored
      tbl[22] = mk(0, 1, 1, 1, 0, 0, 4'd0, 4'd0,  4'd2, 4'd4,  0);
      tbl[23] = mk(0, 1, 1, 1, 0, 0, 4'd0, 4'd0,  4'd2, 4'd4,  0);
      tbl[24] = mk(0, 1, 1, 1, 0, 0, 4'd0, 4'd0,  4'd3, 4'd8,  0); // 4th cycle

      reset = 1'b1; dir = 1'b1; mode = 1'b0; step = 1'b0; hold = 1'b0;
      wr_en = 1'b0; wr_addr = 4'd0; wr_digit = 4'd0;
      r16 = 1'b1; s16 = 1'b0; dir16 = 1'b1; mode16 = 1'b1; hold16 = 1'b0;
      we16 = 1'b0; wa16 = 4'd0; wd16 = 4'd0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 25; i++) begin
         reset = tbl[i].rst; mode = tbl[i].md; dir = tbl[i].dr; step = tbl[i].st;
         hold = tbl[i].hl; wr_en = tbl[i].we; wr_addr = tbl[i].addr;
         wr_digit = tbl[i].dig;
         cyc($sformatf("vec%0d", i), tbl[i].e_idx, tbl[i].e_dig, tbl[i].e_wrap);
      end
      wr_en = 1'b0; step = 1'b0;

      // Hold freezes index and prescaler; release finishes the remaining count.
      cyc("hold pre1", 4'd3, 4'd8, 1'b0);                    // pres 1
      cyc("hold pre2", 4'd3, 4'd8, 1'b0);                    // pres 2
      hold = 1'b1;
      for (int i = 0; i < 10; i++) cyc($sformatf("hold%0d", i), 4'd3, 4'd8, 1'b0);
      hold = 1'b0;
      cyc("hold rel1", 4'd3, 4'd8, 1'b0);                    // pres 3
      cyc("hold rel2", 4'd4, 4'd3, 1'b0);                    // advance

      // Direction change mid-count applies to the next advance only.
      cyc("dir a", 4'd4, 4'd3, 1'b0);                        // pres 1
      dir = 1'b0;
      cyc("dir b", 4'd4, 4'd3, 1'b0);
      cyc("dir c", 4'd4, 4'd3, 1'b0);
      cyc("dir d", 4'd3, 4'd8, 1'b0);
      for (int i = 0; i < 3; i++) cyc($sformatf("dir after%0d", i), 4'd3, 4'd8, 1'b0);

      // Prescaler now at 3; a manual-mode cycle must clear it.
      mode = 1'b0;
      cyc("mode clr", 4'd3, 4'd8, 1'b0);
      mode = 1'b1;
      for (int i = 0; i < 3; i++) cyc($sformatf("mode cnt%0d", i), 4'd3, 4'd8, 1'b0);
      cyc("mode adv", 4'd2, 4'd4, 1'b0);

      // Reset mid-count discards progress; first advance PRESCALE cycles later.
      cyc("rst mid a", 4'd2, 4'd4, 1'b0);
      cyc("rst mid b", 4'd2, 4'd4, 1'b0);
      reset = 1'b1;
      cyc("rst mid r", 4'd0, 4'd6, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc($sformatf("rst cnt%0d", i), 4'd0, 4'd6, 1'b0);
      cyc("rst adv", 4'd4, 4'd3, 1'b1);                      // auto backward wrap
      cyc("rst adv+1", 4'd4, 4'd3, 1'b0);

      // SEQ_LEN=16, PRESCALE=2 forward auto run with step toggling throughout.
      @(posedge clk);
      #1;
      r16 = 1'b0;
      for (int n = 1; n <= 34; n++) begin
         s16 = n[0];
         @(posedge clk);
         #1;
         check($sformatf("len16 idx n=%0d", n), {4'd0, idx16}, 8'((n / 2) % 16));
         check($sformatf("len16 wrap n=%0d", n), {7'd0, wrap16}, {7'd0, (n == 32)});
         if (n == 30) check("len16 hex idx15", {1'b0, hex16}, {1'b0, seg(4'd0)});
         if (n == 32) check("len16 hex idx0", {1'b0, hex16}, {1'b0, seg(4'd6)});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 5, number of sequence entries (legal 2..16).
REQ-002 SHALL have parameter PRESCALE, default 4, clock cycles per auto-advance (legal 1..65535).
REQ-003 SHALL use a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 dir  input  1  1 = advance forward (index+1), 0 = backward (index-1).
REQ-007 mode  input  1  0 = manual step, 1 = auto-advance.
REQ-008 step  input  1  manual advance request, sampled each clk.
REQ-009 hold  input  1  freezes index and prescaler.
REQ-010 wr_en  input  1  sequence-entry write strobe.
REQ-011 wr_addr  input  4  entry to write.
REQ-012 wr_digit  input  4  value to write (0..15).
REQ-013 hex  output  7  active-low segments {g,f,e,d,c,b,a} for entry at current index.
REQ-014 idx  output  4  current index.
REQ-015 wrap  output  1  one-cycle registered wrap pulse.

Function
REQ-016 SHALL hold SEQ_LEN 4-bit entries in registers; idx ranges 0..SEQ_LEN-1 only.
REQ-017 Advance event: mode=0 and step=1 and hold=0, or mode=1 and prescaler=PRESCALE-1 and hold=0; step ignored when mode=1.
REQ-018 On advance, idx SHALL update at the same clk edge: forward SEQ_LEN-1 -> 0, backward 0 -> SEQ_LEN-1, else +/-1.
REQ-019 Prescaler: counts 0..PRESCALE-1 while mode=1 and hold=0, clears to 0 on advance; held at value when hold=1; cleared to 0 whenever mode=0.
REQ-020 wrap SHALL be 1 for exactly the cycle after an advance that wraps (either direction), else 0.
REQ-021 hex SHALL be combinational from entry[idx]: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
REQ-022 wr_en with wr_addr < SEQ_LEN SHALL write wr_digit at the clk edge; wr_addr >= SEQ_LEN ignored.
REQ-023 Write to entry at current idx coincident with advance: write lands, idx moves; hex reflects new entry[new idx] after the edge.
REQ-024 Writes SHALL proceed regardless of hold and mode.
REQ-025 Mid-run dir change SHALL take effect on the next advance; no extra advance.

Reset
REQ-026 reset SHALL have priority over all inputs, including wr_en.
REQ-027 After reset: idx=0, prescaler=0, wrap=0, entries 0..4 = 6,0,4,8,3, entries 5..SEQ_LEN-1 = 0.
REQ-028 After reset hex SHALL be 0000010 (digit 6).
REQ-029 reset mid-count SHALL discard prescaler progress; first auto-advance occurs PRESCALE cycles after reset deasserts.

Configuration
REQ-030 Macro SEQ_PLAYER_BLANK_EN.
REQ-031 Defined: entry values 10..15 SHALL drive hex=1111111 (blank).
REQ-032 Undefined: 10..15 SHALL drive A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.

Verification
REQ-033 Reset, mode=0, dir=1, step pulsed 5 times -> hex 0000010,1000000,0011001,0000000,0110000, then 0000010 with wrap=1 one cycle.
REQ-034 Reset, mode=0, dir=0, one step -> idx=4, hex=0110000, wrap=1 next cycle.
REQ-035 mode=1, PRESCALE=4, hold=0 -> idx increments every 4 cycles; hold=1 for 10 cycles -> idx and prescaler frozen, resume completes remaining count.
REQ-036 Write wr_addr=2 wr_digit=12 then step to idx 2 -> hex 1000110 without macro, 1111111 with SEQ_PLAYER_BLANK_EN.
REQ-037 wr_en with wr_addr=7 at SEQ_LEN=5 -> no entry changes; reset asserted with wr_en=1 -> entries equal defaults.
REQ-038 SEQ_LEN=16 forward auto run -> idx 15 -> 0 with wrap=1; step ignored throughout.
